// File: rtl/layer_weight_loader_if.sv
// Config-stream interface for layer_weight_loader.
// Carries the AXI-stream style word handshake from the config port to the loader.
interface layer_weight_loader_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/layer_weight_loader.sv
// layer_weight_loader: replays a flat stream of per-neuron weights and biases
// as single-cycle weight_valid/bias_valid strobes tagged with layer and neuron.
// Optional feature macro: WLOAD_CHECKSUM_EN adds a trailer word carrying the
// running sum of the stream; a mismatch raises err. Without it, checksum is 0.
module layer_weight_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int LAYER_NO   = 1,
  parameter int NUM_NEURON = 64,
  parameter int NUM_WEIGHT = 128
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  layer_weight_loader_if.slave      s,
  output logic                      weight_valid,
  output logic [DATA_WIDTH-1:0]     weight_value,
  output logic                      bias_valid,
  output logic [DATA_WIDTH-1:0]     bias_value,
  output logic [NUM_NEURON-1:0]     bias_sel,
  output logic [2*DATA_WIDTH:0]     config_layer_num,
  output logic [2*DATA_WIDTH:0]     config_neuron_num,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [DATA_WIDTH-1:0]     checksum
);

  localparam int CW  = 2*DATA_WIDTH+1;
  localparam int WCW = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;
  localparam int NCW = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;
  localparam logic [WCW-1:0] LAST_W = WCW'(NUM_WEIGHT-1);
  localparam logic [NCW-1:0] LAST_N = NCW'(NUM_NEURON-1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_B,
    FIN
`ifdef WLOAD_CHECKSUM_EN
    , CHK
`endif
  } state_t;

  state_t         state;
  logic [WCW-1:0] weight_cnt;
  logic [NCW-1:0] neuron_cnt;
  logic           accept;

`ifdef WLOAD_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum;
  assign checksum = sum;
  assign s.tready = (state == LOAD_W) || (state == LOAD_B) || (state == CHK);
`else
  assign checksum = '0;
  assign s.tready = (state == LOAD_W) || (state == LOAD_B);
`endif

  assign accept = s.tvalid & s.tready;

  // Sequencer: walks weights then bias per neuron and registers every output strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      weight_cnt        <= '0;
      neuron_cnt        <= '0;
      weight_valid      <= 1'b0;
      weight_value      <= '0;
      bias_valid        <= 1'b0;
      bias_value        <= '0;
      bias_sel          <= '0;
      config_layer_num  <= '0;
      config_neuron_num <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
`ifdef WLOAD_CHECKSUM_EN
      sum               <= '0;
`endif
    end else begin
      weight_valid      <= 1'b0;
      bias_valid        <= 1'b0;
      bias_sel          <= '0;
      done              <= 1'b0;
      config_neuron_num <= CW'(neuron_cnt);
      case (state)
        IDLE: begin
          if (start) begin
            state            <= LOAD_W;
            busy             <= 1'b1;
            err              <= 1'b0;
            config_layer_num <= CW'(LAYER_NO);
            weight_cnt       <= '0;
            neuron_cnt       <= '0;
`ifdef WLOAD_CHECKSUM_EN
            sum              <= '0;
`endif
          end
        end
        LOAD_W: begin
          if (accept) begin
            weight_valid <= 1'b1;
            weight_value <= s.tdata;
            if (s.tlast) err <= 1'b1;
`ifdef WLOAD_CHECKSUM_EN
            sum <= sum + s.tdata;
`endif
            if (weight_cnt == LAST_W) begin
              state <= LOAD_B;
            end else begin
              weight_cnt <= weight_cnt + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (accept) begin
            bias_valid <= 1'b1;
            bias_value <= s.tdata;
            bias_sel   <= NUM_NEURON'(1) << neuron_cnt;
            weight_cnt <= '0;
`ifdef WLOAD_CHECKSUM_EN
            sum <= sum + s.tdata;
`endif
            if (neuron_cnt == LAST_N) begin
              neuron_cnt <= '0;
`ifdef WLOAD_CHECKSUM_EN
              state <= CHK;
              if (s.tlast) err <= 1'b1;
`else
              state <= FIN;
              if (!s.tlast) err <= 1'b1;
`endif
            end else begin
              neuron_cnt <= neuron_cnt + 1'b1;
              state      <= LOAD_W;
              if (s.tlast) err <= 1'b1;
            end
          end
        end
`ifdef WLOAD_CHECKSUM_EN
        CHK: begin
          if (accept) begin
            if (!s.tlast || (s.tdata != sum)) err <= 1'b1;
            state <= FIN;
          end
        end
`endif
        FIN: begin
          state            <= IDLE;
          done             <= 1'b1;
          busy             <= 1'b0;
          config_layer_num <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
